// File: rtl/engine_chain_param.sv
// One-hot NFA chain matching a literal/class rule with optional class* loops; one byte per en cycle.
// Match outputs and done appear the cycle after the deciding byte; no backpressure, en is always accepted.
module engine_chain_param #(
   parameter int                      NUM_STATES  = 22,
   parameter int                      NUM_CLASSES = 128,
   parameter logic [NUM_STATES*8-1:0] CLASS_SEL   = '0,
   parameter logic [NUM_STATES-1:0]   LOOP_MASK   = '0,
   parameter bit                      ANCHORED    = 1'b0,
   parameter int                      DEPTH       = 0,
   parameter int                      OFS_W       = 16,
   parameter int                      CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sod,
   input  logic                   en,
   input  logic                   eod,
   input  logic [NUM_CLASSES-1:0] in_class,
   output logic                   match,
   output logic                   match_pulse,
   output logic [OFS_W-1:0]       match_offset,
   output logic [CNT_W-1:0]       match_count,
   output logic                   done
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_STOP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_STATES-1:0] r_active;
   logic [OFS_W-1:0]      r_byte_cnt;
   logic                  r_match;
   logic                  r_match_pulse;
   logic [OFS_W-1:0]      r_match_offset;
   logic [CNT_W-1:0]      r_match_count;
   logic                  r_done;

   logic [NUM_STATES-1:0] w_cls;
   logic [NUM_STATES-1:0] w_reach;
   logic [NUM_STATES-1:0] w_next;
   logic                  w_limit;
   logic                  w_scan_en;
   logic                  w_proc;
   logic                  w_hit;
   logic                  w_stop;
   logic                  w_unused;

   if (NUM_STATES < 2) begin : g_bad_states
      $error("engine_chain_param: NUM_STATES must be at least 2");
   end
   if (LOOP_MASK[NUM_STATES-1]) begin : g_bad_loop
      $error("engine_chain_param: the final chain position cannot be a loop");
   end

   // Class lines not selected by any position are intentionally left unread.
   assign w_unused = ^in_class;

   assign w_reach[0] = ANCHORED ? (r_byte_cnt == '0) : 1'b1;

   for (genvar k = 0; k < NUM_STATES; k++) begin : g_chain
      localparam int SEL = int'(CLASS_SEL[8*k +: 8]);
      if (SEL < NUM_CLASSES) begin : g_sel
         assign w_cls[k] = in_class[SEL];
      end else begin : g_nosel
         assign w_cls[k] = 1'b0;
      end
      assign w_next[k] = w_cls[k] & (w_reach[k] | (LOOP_MASK[k] & r_active[k]));
      // A loop position may match zero bytes, so reachability passes straight through it.
      if (k < NUM_STATES-1) begin : g_reach
         assign w_reach[k+1] = r_active[k] | (LOOP_MASK[k] & w_reach[k]);
      end
   end

   if (DEPTH == 0) begin : g_nolimit
      assign w_limit = 1'b0;
   end else begin : g_limit
      localparam logic [OFS_W-1:0] DEPTH_V = OFS_W'(DEPTH);
      assign w_limit = (r_byte_cnt >= DEPTH_V);
   end

   assign w_scan_en = (r_state == S_SCAN) & en & ~sod;
   assign w_proc    = w_scan_en & ~w_limit;
   assign w_hit     = w_proc & w_next[NUM_STATES-1];
   assign w_stop    = w_scan_en & (w_limit | eod);

   always_comb begin
      w_state_nxt = r_state;
      if (sod) begin
         w_state_nxt = S_SCAN;
      end else if (w_stop) begin
         w_state_nxt = S_STOP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active       <= '0;
         r_byte_cnt     <= '0;
         r_match        <= 1'b0;
         r_match_pulse  <= 1'b0;
         r_match_offset <= '0;
         r_match_count  <= '0;
         r_done         <= 1'b0;
      end else begin
         r_match_pulse <= 1'b0;
         r_done        <= w_stop;
         if (sod) begin
            r_active       <= '0;
            r_byte_cnt     <= '0;
            r_match        <= 1'b0;
            r_match_offset <= '0;
            r_match_count  <= '0;
         end else if (w_proc) begin
            r_active <= w_next;
            if (r_byte_cnt != '1) begin
               r_byte_cnt <= r_byte_cnt + OFS_W'(1);
            end
            if (w_hit) begin
               r_match <= 1'b1;
               if (r_match_count != '1) begin
                  r_match_count <= r_match_count + CNT_W'(1);
               end
               if (!r_match) begin
                  r_match_offset <= r_byte_cnt;
                  r_match_pulse  <= 1'b1;
               end
            end
         end else if (w_scan_en) begin
            // Byte arrived past the depth limit: drop it and flush the chain.
            r_active <= '0;
         end
      end
   end

   assign match        = r_match;
   assign match_pulse  = r_match_pulse;
   assign match_offset = r_match_offset;
   assign match_count  = r_match_count;
   assign done         = r_done;

endmodule

// File: tb/tb_engine_chain_param.sv
// Scoreboard bench: five engine configurations driven from one byte bus, each started by its own sod.
module tb_engine_chain_param;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [4:0]   sod_v;
   logic         en;
   logic         eod;
   logic [128:0] cls;

   logic        m [5];
   logic        p [5];
   logic        d [5];
   logic [15:0] o [5];
   logic [7:0]  c [5];
   logic [1:0]  c4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int cur    = 0;

   typedef struct {
      int inst;
      int cyc;
      int m;
      int ofs;
      int cnt;
   } exp_t;

   exp_t pq[$];
   exp_t dq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // abc, unanchored
   engine_chain_param #(.NUM_STATES(3), .NUM_CLASSES(129), .CLASS_SEL(24'h636261)) u0 (
      .clk(clk), .rst(rst), .sod(sod_v[0]), .en(en), .eod(eod), .in_class(cls),
      .match(m[0]), .match_pulse(p[0]), .match_offset(o[0]), .match_count(c[0]), .done(d[0]));
   // abc, anchored
   engine_chain_param #(.NUM_STATES(3), .NUM_CLASSES(129), .CLASS_SEL(24'h636261), .ANCHORED(1'b1)) u1 (
      .clk(clk), .rst(rst), .sod(sod_v[1]), .en(en), .eod(eod), .in_class(cls),
      .match(m[1]), .match_pulse(p[1]), .match_offset(o[1]), .match_count(c[1]), .done(d[1]));
   // F : [^\r\n]* < >   (class line 128 = any byte except CR/LF)
   engine_chain_param #(.NUM_STATES(5), .NUM_CLASSES(129), .CLASS_SEL(40'h3E3C803A46), .LOOP_MASK(5'b00100)) u2 (
      .clk(clk), .rst(rst), .sod(sod_v[2]), .en(en), .eod(eod), .in_class(cls),
      .match(m[2]), .match_pulse(p[2]), .match_offset(o[2]), .match_count(c[2]), .done(d[2]));
   // abc, depth limited to offsets 0..3
   engine_chain_param #(.NUM_STATES(3), .NUM_CLASSES(129), .CLASS_SEL(24'h636261), .DEPTH(4)) u3 (
      .clk(clk), .rst(rst), .sod(sod_v[3]), .en(en), .eod(eod), .in_class(cls),
      .match(m[3]), .match_pulse(p[3]), .match_offset(o[3]), .match_count(c[3]), .done(d[3]));
   // aa with a 2-bit saturating count
   engine_chain_param #(.NUM_STATES(2), .NUM_CLASSES(129), .CLASS_SEL(16'h6161), .CNT_W(2)) u4 (
      .clk(clk), .rst(rst), .sod(sod_v[4]), .en(en), .eod(eod), .in_class(cls),
      .match(m[4]), .match_pulse(p[4]), .match_offset(o[4]), .match_count(c4), .done(d[4]));
   assign c[4] = {6'd0, c4};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [128:0] dec(input logic [7:0] b);
      logic [128:0] v;
      v = '0;
      v[int'(b) & 127] = 1'b1;
      if (b != 8'h0A && b != 8'h0D) v[128] = 1'b1;
      return v;
   endfunction

   task automatic start(input int inst);
      @(posedge clk); #1;
      cur          = inst;
      sod_v        = '0;
      sod_v[inst]  = 1'b1;
      en           = 1'b0;
      eod          = 1'b0;
   endtask

   // pofs >= 0: first-match pulse expected after this byte; dm >= 0: done expected after it.
   task automatic send(input logic [7:0] b, input bit last, input int pofs,
                       input int dm, input int dofs, input int dcnt);
      exp_t t;
      @(posedge clk); #1;
      sod_v = '0;
      en    = 1'b1;
      eod   = last;
      cls   = dec(b);
      if (pofs >= 0) begin
         t.inst = cur; t.cyc = cyc + 1; t.m = 1; t.ofs = pofs; t.cnt = 0;
         pq.push_back(t);
      end
      if (dm >= 0) begin
         t.inst = cur; t.cyc = cyc + 1; t.m = dm; t.ofs = dofs; t.cnt = dcnt;
         dq.push_back(t);
      end
   endtask

   task automatic b(input logic [7:0] ch);
      send(ch, 1'b0, -1, -1, 0, 0);
   endtask

   task automatic idle(input int n, input bit e);
      repeat (n) begin
         @(posedge clk); #1;
         sod_v = '0;
         en    = 1'b0;
         eod   = e;
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      check({tag, "_match"}, int'(m[i]), 0);
      check({tag, "_pulse"}, int'(p[i]), 0);
      check({tag, "_offset"}, int'(o[i]), 0);
      check({tag, "_count"}, int'(c[i]), 0);
      check({tag, "_done"}, int'(d[i]), 0);
   endtask

   always @(negedge clk) begin
      exp_t t;
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            if (p[i]) begin
               if (pq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_pulse: engine %0d offset %0d, expected no pulse (cycle %0d)", i, o[i], cyc);
               end else begin
                  t = pq.pop_front();
                  check("pulse_engine", i, t.inst);
                  check("pulse_cycle", cyc, t.cyc);
                  check("pulse_offset", int'(o[i]), t.ofs);
                  check("pulse_match", int'(m[i]), 1);
               end
            end
            if (d[i]) begin
               if (dq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: engine %0d, expected no done (cycle %0d)", i, cyc);
               end else begin
                  t = dq.pop_front();
                  check("done_engine", i, t.inst);
                  check("done_cycle", cyc, t.cyc);
                  check("done_match", int'(m[i]), t.m);
                  check("done_offset", int'(o[i]), t.ofs);
                  check("done_count", int'(c[i]), t.cnt);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      sod_v = '0; en = 1'b0; eod = 1'b0; cls = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) check_zero(i, "reset");
      rst = 1'b0;

      // "xxabc": hold across an idle cycle and an eod without en
      start(0);
      b("x"); b("x");
      idle(1, 1'b1);
      b("a"); b("b");
      send("c", 1'b1, 4, 1, 4, 1);
      idle(3, 1'b0);

      // "abcabc": two matches, single pulse
      start(0);
      b("a"); b("b"); send("c", 1'b0, 2, -1, 0, 0);
      b("a"); b("b"); send("c", 1'b1, -1, 1, 2, 2);
      idle(3, 1'b0);

      // anchored
      start(1);
      b("x"); b("a"); b("b"); send("c", 1'b1, -1, 0, 0, 0);
      idle(2, 1'b0);
      start(1);
      b("a"); b("b"); send("c", 1'b1, 2, 1, 2, 1);
      idle(3, 1'b0);

      // loop pattern
      start(2);
      b("F"); b(":"); b("<"); send(">", 1'b1, 3, 1, 3, 1);
      idle(2, 1'b0);
      start(2);
      b("F"); b(":"); b("z"); b("z"); b("<"); send(">", 1'b1, 5, 1, 5, 1);
      idle(2, 1'b0);
      start(2);
      b("F"); b(":"); b("z"); b(8'h0A); b("<"); send(">", 1'b1, -1, 0, 0, 0);
      idle(3, 1'b0);

      // depth limit: offset 4 triggers stop, further bytes and eod ignored
      start(3);
      b("x"); b("x"); b("x"); b("a");
      send("b", 1'b0, -1, 0, 0, 0);
      send("c", 1'b1, -1, -1, 0, 0);
      idle(3, 1'b0);
      start(3);
      b("x"); b("a"); b("b"); send("c", 1'b0, 3, -1, 0, 0);
      send("x", 1'b0, -1, 1, 3, 1);
      idle(3, 1'b0);

      // five overlapping hits into a 2-bit count
      start(4);
      b("a"); send("a", 1'b0, 1, -1, 0, 0);
      b("a"); b("a"); b("a");
      send("a", 1'b1, -1, 1, 1, 3);
      idle(3, 1'b0);

      // asynchronous reset mid-packet, after a match has been recorded
      start(0);
      b("a"); b("b"); send("c", 1'b0, 2, -1, 0, 0);
      b("a"); b("b");
      @(posedge clk); #1;
      en  = 1'b0;
      eod = 1'b0;
      rst = 1'b1;
      #1;
      check_zero(0, "async_rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      start(0);
      send("c", 1'b1, -1, 0, 0, 0);
      idle(5, 1'b0);

      check("pulse_queue_left", pq.size(), 0);
      check("done_queue_left", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/engine_chain_param.md
Name: engine_chain_param

Overview:
- Parametrised successor to the per-rule fixed NFA engines: one generic one-hot NFA chain matching a PCRE-style rule of literal/class positions with optional `[class]*` self-loop positions.
- Consumes the shared one-hot character-class decode lines, one payload byte per enabled cycle.
- Adds what the fixed engines lack: selectable anchoring, an offset depth limit, packet framing via sod/eod, and match reporting (first-match offset, saturating match count, end-of-packet done).

Parameters:
NUM_STATES, 22, number of chain positions (≥2)
NUM_CLASSES, 128, width of the class-line bus
CLASS_SEL, all-zero, NUM_STATES×8-bit flattened vector; byte k = class-line index tested by position k
LOOP_MASK, 0, NUM_STATES bits; bit k=1 makes position k a `class*` loop (zero-or-more); bit NUM_STATES-1 must be 0 (elaboration error otherwise)
ANCHORED, 0, 1: a match may only start at payload offset 0
DEPTH, 0, 0 = unlimited; else only offsets 0..DEPTH-1 are scanned
OFS_W, 16, width of byte offset counter and match_offset
CNT_W, 8, width of match_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
sod  in  1  start of packet; one-cycle pulse, carries no byte
en  in  1  byte valid; in_class is sampled when en=1
eod  in  1  qualifies en: the current byte is the packet's last
in_class  in  NUM_CLASSES  one-hot class lines for the current byte
match  out  1  sticky: rule matched in this packet
match_pulse  out  1  one-cycle pulse on the first match of a packet
match_offset  out  OFS_W  offset of the byte completing the first match
match_count  out  CNT_W  completed matches in packet, saturating
done  out  1  one-cycle pulse after the eod byte, or after the depth-limit stop

Behaviour:
- Reset (async, rst=1): all outputs, active[] regs, byte_cnt and FSM → 0 / IDLE.
- FSM states:
  - IDLE: ignores en/eod; sod → SCAN.
  - SCAN: processes bytes.
  - STOP: ignores en/eod; sod → SCAN.
  - sod in any state: clears active[], byte_cnt, match, match_offset, match_count; enters SCAN next cycle. sod has priority over a simultaneous en, which is dropped.
- Chain logic (comb.), position k, c_k = in_class[CLASS_SEL[k]]:
  - reach_0 = start, where start = (byte_cnt==0) if ANCHORED else 1.
  - reach_{k+1} = active_k | (LOOP_MASK[k] & reach_k).
  - next_k = c_k & (reach_k | (LOOP_MASK[k] & active_k)).
- Registers on each clk edge with SCAN & en & ~limit: active_k ← next_k, byte_cnt ← byte_cnt+1, saturating at 2^OFS_W−1. When en=0, active[] and byte_cnt hold.
- limit = (DEPTH≠0) & (byte_cnt ≥ DEPTH). An en byte while limit=1 is not processed: FSM → STOP, done pulses next cycle, active[] cleared.
- hit = SCAN & en & ~limit & next_{NUM_STATES-1}. On the edge with hit:
  - match ← 1; match_count ← match_count+1, saturating at all-ones.
  - If match was 0: match_offset ← byte_cnt and match_pulse ← 1 for one cycle.
  - Latency: outputs visible in the cycle after the completing byte's en cycle.
- Overlapping matches each count: each cycle with hit adds 1.
- eod with en in SCAN:
  - The byte is processed normally; its hit is counted.
  - FSM → STOP; done pulses the next cycle.
  - match, match_offset and match_count hold until the next sod/rst.
- eod without en: ignored.
- Reset mid-packet: immediate clear; done is not pulsed.

Test Plan:
1. NUM_STATES=3, classes 'a','b','c', ANCHORED=0; sod, bytes "xxabc" → match_pulse the cycle after byte 4; match_offset=4, match_count=1; eod on byte 4 → done next cycle.
2. Same config, bytes "abcabc" → match_count=2, match_offset=2, match_pulse only once.
3. ANCHORED=1, bytes "xabc" → match stays 0; then sod, "abc" → match_offset=2.
4. Pattern `F : [^\r\n]* < >` (LOOP_MASK bit2):
   - "F:<>" → match, offset 3.
   - "F:zz<>" → offset 5.
   - "F:z\n<>" → no match.
5. DEPTH=4, bytes "xxxabc" → no match; done pulses after the byte at offset 4; later bytes are ignored (STOP).
6. rst asserted mid-match after "ab" → all outputs 0 immediately; "c" after sod gives no match. CNT_W=2 with 5 overlapping hits → match_count saturates at 3.
